// File: rtl/proc_queue.sv
// proc_queue: circular FIFO of parsed packet headers plus output-port bitmaps
// between producer and consumer stages, with registered head outputs and a drop counter.
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 16
`endif
`ifndef NUM_PORTS
`define NUM_PORTS 4
`endif
`ifndef ZERO_BYTE
`define ZERO_BYTE 8'h00
`endif

module proc_queue #(
   parameter int DEPTH      = 4,
   parameter int HDR_LEN    = `HDR_MAX_LEN,
   parameter int NUM_PORTS  = `NUM_PORTS,
   parameter int AF_THRESH  = DEPTH-1,
   parameter int DROP_CNT_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_i,
   input  logic [HDR_LEN*8-1:0]        pkt_hdr_i,
   input  logic [NUM_PORTS-1:0]        out_port_i,
   input  logic                        rd_i,
   output logic [HDR_LEN*8-1:0]        pkt_hdr_o,
   output logic [NUM_PORTS-1:0]        out_port_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic                        almost_full_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic [DROP_CNT_W-1:0]       drop_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int HDR_W = HDR_LEN * 8;
   localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [HDR_W-1:0] ZERO_HDR = {HDR_LEN{`ZERO_BYTE}};

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + DROP_CNT_W'(1);
   endfunction

   logic [HDR_W-1:0]      r_mem_hdr  [DEPTH];
   logic [NUM_PORTS-1:0]  r_mem_port [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_empty;
   logic                  r_full;
   logic                  r_af;
   logic [DROP_CNT_W-1:0] r_drop;
   logic [HDR_W-1:0]      r_head_hdr;
   logic [NUM_PORTS-1:0]  r_head_port;

   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_wr_rej;
   logic [PTR_W-1:0]      w_rd_ptr_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  w_bypass;
   logic [HDR_W-1:0]      w_head_hdr_nxt;
   logic [NUM_PORTS-1:0]  w_head_port_nxt;

   assign w_rd_acc     = rd_i && !r_empty;
   // A pop on a full queue frees the slot the concurrent write lands in.
   assign w_wr_acc     = wr_i && (!r_full || w_rd_acc);
   assign w_wr_rej     = wr_i && !w_wr_acc;
   assign w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
   assign w_cnt_nxt    = r_cnt + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
   // The new head is the entry being written this edge when it lands at the next read slot.
   assign w_bypass     = w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt);

   always_comb begin
      w_head_hdr_nxt  = ZERO_HDR;
      w_head_port_nxt = '0;
      if (w_cnt_nxt != '0) begin
         if (w_bypass) begin
            w_head_hdr_nxt  = pkt_hdr_i;
            w_head_port_nxt = out_port_i;
         end else begin
            w_head_hdr_nxt  = r_mem_hdr[w_rd_ptr_nxt];
            w_head_port_nxt = r_mem_port[w_rd_ptr_nxt];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem_hdr[r_wr_ptr]  <= pkt_hdr_i;
         r_mem_port[r_wr_ptr] <= out_port_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_af        <= 1'b0;
         r_drop      <= '0;
         r_head_hdr  <= ZERO_HDR;
         r_head_port <= '0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_empty     <= (w_cnt_nxt == '0);
         r_full      <= (w_cnt_nxt == FULL_LVL);
         r_af        <= (w_cnt_nxt >= AF_LVL);
         if (w_wr_rej) r_drop <= sat_inc(r_drop);
         r_head_hdr  <= w_head_hdr_nxt;
         r_head_port <= w_head_port_nxt;
      end
   end

   assign pkt_hdr_o     = r_head_hdr;
   assign out_port_o    = r_head_port;
   assign empty_o       = r_empty;
   assign full_o        = r_full;
   assign almost_full_o = r_af;
   assign count_o       = r_cnt;
   assign drop_cnt_o    = r_drop;

endmodule

// File: tb/tb_proc_queue.sv
// Directed bench for proc_queue: DEPTH=4 queue plus a twin with a 2-bit drop counter.
module tb_proc_queue;

   localparam int DEPTH = 4;
   localparam int HL    = 4;
   localparam int HW    = HL * 8;
   localparam int NP    = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           wr, rd;
   logic [HW-1:0]  hdr_in;
   logic [NP-1:0]  port_in;

   logic [HW-1:0]  hdr_o;
   logic [NP-1:0]  port_o;
   logic           empty, full, af;
   logic [2:0]     cnt;
   logic [15:0]    drop;

   logic [HW-1:0]  s_hdr_o;
   logic [NP-1:0]  s_port_o;
   logic           s_empty, s_full, s_af;
   logic [2:0]     s_cnt;
   logic [1:0]     s_drop;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   proc_queue #(.DEPTH(DEPTH), .HDR_LEN(HL), .NUM_PORTS(NP), .AF_THRESH(DEPTH-1), .DROP_CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .wr_i(wr), .pkt_hdr_i(hdr_in), .out_port_i(port_in), .rd_i(rd),
      .pkt_hdr_o(hdr_o), .out_port_o(port_o), .empty_o(empty), .full_o(full),
      .almost_full_o(af), .count_o(cnt), .drop_cnt_o(drop)
   );

   proc_queue #(.DEPTH(DEPTH), .HDR_LEN(HL), .NUM_PORTS(NP), .AF_THRESH(DEPTH-1), .DROP_CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .wr_i(wr), .pkt_hdr_i(hdr_in), .out_port_i(port_in), .rd_i(rd),
      .pkt_hdr_o(s_hdr_o), .out_port_o(s_port_o), .empty_o(s_empty), .full_o(s_full),
      .almost_full_o(s_af), .count_o(s_cnt), .drop_cnt_o(s_drop)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [HW-1:0] mk_hdr(input logic [7:0] b);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic drive(input logic w, input logic r, input logic [7:0] b, input logic [NP-1:0] p);
      wr      = w;
      rd      = r;
      hdr_in  = mk_hdr(b);
      port_in = p;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected head is byte0 b / port p when cnt > 0, all-zero otherwise.
   task automatic chk_state(input string tag, input logic [7:0] b, input logic [NP-1:0] p, input int c);
      chk({tag, ".hdr"},   64'(hdr_o),  (c == 0) ? 64'd0 : 64'(mk_hdr(b)));
      chk({tag, ".port"},  64'(port_o), (c == 0) ? 64'd0 : 64'(p));
      chk({tag, ".count"}, 64'(cnt),    64'(c));
      chk({tag, ".empty"}, 64'(empty),  64'(c == 0));
      chk({tag, ".full"},  64'(full),   64'(c == DEPTH));
      chk({tag, ".af"},    64'(af),     64'(c >= DEPTH-1));
   endtask

   initial begin
      logic [7:0]    eb [4];
      logic [NP-1:0] ep [4];
      eb = '{8'hC0, 8'hD0, 8'hE0, 8'h00};
      ep = '{4'b0100, 4'b1000, 4'b0101, 4'b0000};

      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, '0);
      repeat (2) tick;
      rst = 1'b0;
      chk_state("reset", 8'h00, '0, 0);
      chk("reset.drop", 64'(drop), 64'd0);

      drive(1'b0, 1'b1, 8'h00, '0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_state("rd_empty", 8'h00, '0, 0);
         chk("rd_empty.drop", 64'(drop), 64'd0);
      end

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'hA0 + 8'(i * 16), 4'(1 << i));
         tick;
         chk_state("push", 8'hA0, 4'b0001, i + 1);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'h00, '0);
         tick;
         if (i < 3) chk_state("pop", 8'hA0 + 8'((i + 1) * 16), 4'(1 << (i + 1)), 3 - i);
         else       chk_state("pop", 8'h00, '0, 0);
      end

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'hA0 + 8'(i * 16), 4'(1 << i));
         tick;
      end
      chk_state("refill", 8'hA0, 4'b0001, 4);
      for (int k = 1; k <= 2; k++) begin
         drive(1'b1, 1'b0, 8'h55, 4'hF);
         tick;
         chk_state("drop_full", 8'hA0, 4'b0001, 4);
         chk("drop_full.drop", 64'(drop), 64'(k));
         chk("drop_full.sat", 64'(s_drop), 64'(k));
      end
      drive(1'b1, 1'b1, 8'hE0, 4'b0101);
      tick;
      chk_state("full_rw", 8'hB0, 4'b0010, 4);
      chk("full_rw.drop", 64'(drop), 64'd2);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'h00, '0);
         tick;
         chk_state("drain", eb[i], ep[i], 3 - i);
      end

      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 8'h10 + 8'(i), 4'(i));
         tick;
      end
      chk_state("wrap_pre", 8'h10, 4'd0, 2);
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 1'b1, 8'h10 + 8'(k + 2), 4'(k + 2));
         tick;
         chk_state("wrap", 8'h10 + 8'(k + 1), 4'(k + 1), 2);
      end
      drive(1'b0, 1'b1, 8'h00, '0);
      tick;
      chk_state("wrap_pop", 8'h1B, 4'd11, 1);
      drive(1'b1, 1'b1, 8'h1C, 4'd12);
      tick;
      chk_state("rw_cnt1", 8'h1C, 4'd12, 1);
      drive(1'b0, 1'b1, 8'h00, '0);
      tick;
      chk_state("rw_cnt1_pop", 8'h00, '0, 0);

      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'hF0 + 8'(i), 4'(i + 1));
         tick;
      end
      chk_state("pre_rst", 8'hF0, 4'd1, 3);
      drive(1'b0, 1'b0, 8'h00, '0);
      #2 rst = 1'b1;
      #1;
      chk_state("async_rst", 8'h00, '0, 0);
      chk("async_rst.drop", 64'(drop), 64'd0);
      chk("async_rst.sat", 64'(s_drop), 64'd0);
      #2 rst = 1'b0;
      drive(1'b1, 1'b0, 8'h77, 4'd6);
      tick;
      chk_state("post_rst", 8'h77, 4'd6, 1);
      drive(1'b0, 1'b1, 8'h00, '0);
      tick;
      chk_state("post_rst_pop", 8'h00, '0, 0);

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'h30 + 8'(i * 16), 4'(i + 3));
         tick;
      end
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 1'b0, 8'h99, 4'h9);
         tick;
         chk_state("sat", 8'h30, 4'd3, 4);
         chk("sat.drop", 64'(drop), 64'(k));
         chk("sat.sat", 64'(s_drop), (k > 3) ? 64'd3 : 64'(k));
      end
      drive(1'b0, 1'b0, 8'h00, '0);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
